// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu -- registered integer ALU for the datapath execute stage.
//
// Computes one operation per clock on A (and B) and registers the result
// together with a zero flag. Latency is one cycle and a new operation is
// accepted every cycle; there is no handshake.
//
// Parameters
//   WIDTH    operand/result width (default 32)
//   SHAMT_W  width of shift_amount, $clog2(WIDTH) (5 at default)
//
// Ports
//   clk           in   1        rising-edge clock
//   rst           in   1        synchronous active-high reset (result=0, zero=1)
//   A             in   WIDTH    operand A, also the shifted/rotated operand
//   B             in   WIDTH    operand B, ignored by shift/rotate ops
//   op_code       in   4        operation select
//   shift_amount  in   SHAMT_W  shift/rotate distance
//   result        out  WIDTH    registered result
//   zero          out  1        registered flag, 1 when result == 0
//
// Opcodes
//   0000 ADD  0001 SUB  0010 AND  0011 OR   0100 XOR
//   0101 SRL  0110 SLL  0111 ROL  1000 ROR
//   1001..1111 produce 0 in the default build.
//
// Build option
//   ALU_EXT_OPS_EN  when defined, also decodes 1001 SRA, 1010 SLT,
//                   1011 SLTU and 1100 NOR; 1101..1111 still produce 0.
// -----------------------------------------------------------------------------
module alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [3:0]         op_code,
  input  logic [SHAMT_W-1:0] shift_amount,
  output logic [WIDTH-1:0]   result,
  output logic               zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_ROL  = 4'b0111;
  localparam logic [3:0] OP_ROR  = 4'b1000;
`ifdef ALU_EXT_OPS_EN
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`endif

  logic [WIDTH-1:0]   result_d, result_q;
  logic               zero_d, zero_q;

  // Rotates are done by shifting A concatenated with itself: the bits that
  // fall off one end reappear from the other copy. A distance of 0 leaves
  // the selected half equal to A.
  logic [2*WIDTH-1:0] rot_l_wide;
  logic [2*WIDTH-1:0] rot_r_wide;
  logic [WIDTH-1:0]   rol_val;
  logic [WIDTH-1:0]   ror_val;

  always_comb begin
    rot_l_wide = {A, A} << shift_amount;
    rot_r_wide = {A, A} >> shift_amount;
    rol_val    = rot_l_wide[2*WIDTH-1:WIDTH];
    ror_val    = rot_r_wide[WIDTH-1:0];
  end

  always_comb begin
    result_d = '0;
    unique case (op_code)
      OP_ADD:  result_d = A + B;
      OP_SUB:  result_d = A - B;
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_XOR:  result_d = A ^ B;
      OP_SRL:  result_d = A >> shift_amount;
      OP_SLL:  result_d = A << shift_amount;
      OP_ROL:  result_d = rol_val;
      OP_ROR:  result_d = ror_val;
`ifdef ALU_EXT_OPS_EN
      OP_SRA:  result_d = $unsigned($signed(A) >>> shift_amount);
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_NOR:  result_d = ~(A | B);
`endif
      default: result_d = '0;
    endcase
    // Derived from the same next value so the flag can never disagree
    // with the registered result.
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu.sv
// -----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
//
// Inputs are driven on the falling edge and outputs sampled 1 ns after the
// rising edge. Single-cycle behaviour comes from a table of hand-computed
// vectors; reset, latency and back-to-back behaviour use short hand-written
// sequences. Define ALU_EXT_OPS_EN for both DUT and bench to cover the
// extended opcodes.
// -----------------------------------------------------------------------------
module tb_alu;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [3:0]         op_code;
  logic [SHAMT_W-1:0] shift_amount;
  logic [WIDTH-1:0]   result;
  logic               zero;

  alu #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .op_code      (op_code),
    .shift_amount (shift_amount),
    .result       (result),
    .zero         (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [3:0]         op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   exp_result;
    logic               exp_zero;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   failures;

  function automatic void add_vec(string name, logic [3:0] op, logic [WIDTH-1:0] a,
                                  logic [WIDTH-1:0] b, logic [SHAMT_W-1:0] sh,
                                  logic [WIDTH-1:0] exp_result, logic exp_zero);
    vec_t v;
    v.name       = name;
    v.op         = op;
    v.a          = a;
    v.b          = b;
    v.sh         = sh;
    v.exp_result = exp_result;
    v.exp_zero   = exp_zero;
    vecs.push_back(v);
  endfunction

  task automatic check_res(string name, logic [WIDTH-1:0] exp_result, logic exp_zero);
    checks++;
    if (result !== exp_result || zero !== exp_zero) begin
      failures++;
      $display("FAIL %s: got result=%08h zero=%0b, expected result=%08h zero=%0b",
               name, result, zero, exp_result, exp_zero);
    end else begin
      $display("ok   %s: result=%08h zero=%0b", name, result, zero);
    end
  endtask

  // Drive one op on the falling edge, clock it in, sample 1 ns later.
  task automatic apply(logic r, logic [3:0] op, logic [WIDTH-1:0] a,
                       logic [WIDTH-1:0] b, logic [SHAMT_W-1:0] sh);
    @(negedge clk);
    rst          = r;
    op_code      = op;
    A            = a;
    B            = b;
    shift_amount = sh;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; A = '0; B = '0; op_code = 4'b0000; shift_amount = '0;

    // Arithmetic
    add_vec("sub_10_4",     4'b0001, 32'd10,        32'd4, 5'd0, 32'd6,        1'b0);
    add_vec("sub_5_5",      4'b0001, 32'd5,         32'd5, 5'd0, 32'd0,        1'b1);
    add_vec("sub_0_1",      4'b0001, 32'd0,         32'd1, 5'd0, 32'hFFFFFFFF, 1'b0);
    add_vec("add_wrap",     4'b0000, 32'hFFFFFFFF,  32'd1, 5'd0, 32'd0,        1'b1);
    add_vec("add_big",      4'b0000, 32'h12345678,  32'h11111111, 5'd7, 32'h23456789, 1'b0);
    // Logic
    add_vec("and_a_b",      4'b0010, 32'hA, 32'hB, 5'd0, 32'hA, 1'b0);
    add_vec("or_a_b",       4'b0011, 32'hA, 32'hB, 5'd0, 32'hB, 1'b0);
    add_vec("xor_a_b",      4'b0100, 32'hA, 32'hB, 5'd0, 32'h1, 1'b0);
    add_vec("xor_self",     4'b0100, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0, 32'h0, 1'b1);
    // Shifts/rotates (B nonzero to show it is ignored)
    add_vec("srl_32_2",     4'b0101, 32'd32, 32'hFFFF, 5'd2, 32'd8,   1'b0);
    add_vec("sll_32_2",     4'b0110, 32'd32, 32'hFFFF, 5'd2, 32'd128, 1'b0);
    add_vec("rol_32_2",     4'b0111, 32'd32, 32'hFFFF, 5'd2, 32'd128, 1'b0);
    add_vec("ror_32_2",     4'b1000, 32'd32, 32'hFFFF, 5'd2, 32'd8,   1'b0);
    add_vec("sll_msb_out",  4'b0110, 32'h80000000, 32'd0, 5'd1, 32'd0, 1'b1);
    add_vec("ror_1_1",      4'b1000, 32'd1, 32'd0, 5'd1, 32'h80000000, 1'b0);
    add_vec("rol_wrap_4",   4'b0111, 32'h80000001, 32'd0, 5'd4, 32'h00000018, 1'b0);
    add_vec("rol_31",       4'b0111, 32'h00000003, 32'd0, 5'd31, 32'h80000001, 1'b0);
    add_vec("srl_31",       4'b0101, 32'h80000000, 32'd0, 5'd31, 32'h00000001, 1'b0);
    add_vec("srl_sh0",      4'b0101, 32'hC0FFEE01, 32'd5, 5'd0, 32'hC0FFEE01, 1'b0);
    add_vec("sll_sh0",      4'b0110, 32'hC0FFEE01, 32'd5, 5'd0, 32'hC0FFEE01, 1'b0);
    add_vec("rol_sh0",      4'b0111, 32'hC0FFEE01, 32'd5, 5'd0, 32'hC0FFEE01, 1'b0);
    add_vec("ror_sh0",      4'b1000, 32'hC0FFEE01, 32'd5, 5'd0, 32'hC0FFEE01, 1'b0);
`ifdef ALU_EXT_OPS_EN
    add_vec("sra_neg_4",    4'b1001, 32'h80000000, 32'd0, 5'd4, 32'hF8000000, 1'b0);
    add_vec("sra_pos_4",    4'b1001, 32'h40000000, 32'd0, 5'd4, 32'h04000000, 1'b0);
    add_vec("slt_m1_1",     4'b1010, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, 1'b0);
    add_vec("slt_1_m1",     4'b1010, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1);
    add_vec("sltu_m1_1",    4'b1011, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b1);
    add_vec("sltu_1_m1",    4'b1011, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd1, 1'b0);
    add_vec("nor_a_b",      4'b1100, 32'hA, 32'hB, 5'd0, 32'hFFFFFFF4, 1'b0);
    add_vec("op_1101",      4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'd0, 1'b1);
    add_vec("op_1111",      4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'd0, 1'b1);
`else
    add_vec("op_1001",      4'b1001, 32'h80000000, 32'd0, 5'd4, 32'd0, 1'b1);
    add_vec("op_1010",      4'b1010, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, 1'b1);
    add_vec("op_1011",      4'b1011, 32'd1, 32'hFFFFFFFF, 5'd0, 32'd0, 1'b1);
    add_vec("op_1100",      4'b1100, 32'hA, 32'hB, 5'd0, 32'd0, 1'b1);
    add_vec("op_1111",      4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'd0, 1'b1);
`endif

    // Reset overrides an ADD presented at the same edge.
    apply(1'b1, 4'b0000, 32'd5, 32'd3, 5'd0);
    check_res("reset_state", 32'd0, 1'b1);

    // Release reset: ADD appears one cycle later.
    apply(1'b0, 4'b0000, 32'd5, 32'd3, 5'd0);
    check_res("add_5_3", 32'd8, 1'b0);

    // Latency: new inputs must not show before the next rising edge.
    @(negedge clk);
    op_code = 4'b0001; A = 32'd100; B = 32'd1; shift_amount = '0;
    #2;
    check_res("hold_before_edge", 32'd8, 1'b0);
    @(posedge clk);
    #1;
    check_res("sub_after_edge", 32'd99, 1'b0);

    // Table-driven single ops, issued back to back.
    foreach (vecs[i]) begin
      apply(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      check_res(vecs[i].name, vecs[i].exp_result, vecs[i].exp_zero);
    end

    // Mid-run reset after a nonzero result, then recovery.
    apply(1'b0, 4'b0011, 32'hF0, 32'h0F, 5'd0);
    check_res("or_before_rst", 32'hFF, 1'b0);
    apply(1'b1, 4'b0011, 32'hF0, 32'h0F, 5'd0);
    check_res("mid_reset", 32'd0, 1'b1);
    apply(1'b0, 4'b0110, 32'd1, 32'd0, 5'd31);
    check_res("sll_after_rst", 32'h80000000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
